// File: rtl/cache_pkg.sv
// Shared types for the cache memory-side bridge.
package cache_pkg;

  // Widths of a buffered write-back entry; a bridge built with other widths must change these too.
  localparam int unsigned CACHE_DW = 32;
  localparam int unsigned CACHE_AW = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE
  } bridge_state_t;

  typedef struct packed {
    logic [CACHE_AW-1:0] addr;
    logic [CACHE_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/cache_wb_fifo.sv
// Posted write buffer: circular FIFO of write-back entries with a parallel
// address lookup that returns the newest matching entry for read forwarding.
module cache_wb_fifo
  import cache_pkg::*;
#(
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  wb_entry_t           push_entry,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output wb_entry_t           head,
  input  logic [CACHE_AW-1:0] match_addr,
  output logic                match_hit,
  output logic [CACHE_DW-1:0] match_data
);

  localparam int unsigned PTR_W = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W = $clog2(WB_DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  wb_entry_t        entries_q [WB_DEPTH];

  // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Entry storage; validity comes from the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) entries_q[wr_ptr_q] <= push_entry;
  end

  assign full  = (count_q == CNT_W'(WB_DEPTH));
  assign empty = (count_q == '0);
  assign head  = entries_q[rd_ptr_q];

  // Scan oldest to newest so the last match seen is the newest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    match_hit  = 1'b0;
    match_data = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (entries_q[idx].addr == match_addr)) begin
        match_hit  = 1'b1;
        match_data = entries_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/cache_mem_bridge.sv
// Memory-side stage below the cache datapath: posts write-backs into a small
// buffer, forwards buffered data to allocate reads, and otherwise turns
// requests into a single-outstanding valid/ready memory handshake.
module cache_mem_bridge
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = CACHE_DW,
  parameter int unsigned ADDRESS_WIDTH = CACHE_AW,
  parameter int unsigned WB_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  bridge_state_t state_q, state_d;

  logic                     mem_req_valid_q, mem_req_valid_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                     resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]    resp_rdata_q, resp_rdata_d;

  logic            wb_full, wb_empty, wb_hit, wb_pop;
  logic [DATA_WIDTH-1:0] wb_hit_data;
  wb_entry_t       wb_head, wb_push_entry;

  logic wr_acc, rd_acc, mem_hs;

  // Write readiness uses the registered count only, so a same-cycle pop never frees a slot.
  assign req_ready  = !rst && (req_write ? !wb_full : ((state_q == IDLE) && !drain_req));
  assign drain_done = !rst && drain_req && wb_empty && (state_q == IDLE);

  assign wr_acc = req_valid && req_write && req_ready;
  assign rd_acc = req_valid && !req_write && req_ready;
  assign mem_hs = mem_req_valid_q && mem_req_ready;
  assign wb_pop = (state_q == WR_ISSUE) && mem_hs;

  assign wb_push_entry.addr = req_addr;
  assign wb_push_entry.data = req_wdata;

  cache_wb_fifo #(
    .WB_DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (wr_acc),
    .push_entry (wb_push_entry),
    .pop        (wb_pop),
    .full       (wb_full),
    .empty      (wb_empty),
    .head       (wb_head),
    .match_addr (req_addr),
    .match_hit  (wb_hit),
    .match_data (wb_hit_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a read in IDLE takes priority over draining the buffer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_acc && !wb_hit)       state_d = RD_ISSUE;
        else if (!rd_acc && !wb_empty) state_d = WR_ISSUE;
      end
      RD_ISSUE: if (mem_hs)         state_d = RD_WAIT;
      RD_WAIT:  if (mem_resp_valid) state_d = IDLE;
      WR_ISSUE: if (mem_hs)         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Output next values: request fields load on entry to an issue state and hold until accepted.
  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (rd_acc) begin
          if (wb_hit) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = wb_hit_data;
          end else begin
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b0;
            mem_addr_d      = req_addr;
          end
        end else if (!wb_empty) begin
          mem_req_valid_d = 1'b1;
          mem_we_d        = 1'b1;
          mem_addr_d      = wb_head.addr;
          mem_wdata_d     = wb_head.data;
        end
      end
      RD_ISSUE, WR_ISSUE: begin
        if (mem_hs) mem_req_valid_d = 1'b0;
      end
      RD_WAIT: begin
        if (mem_resp_valid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_rdata;
        end
      end
      default: mem_req_valid_d = 1'b0;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Scoreboard bench for cache_mem_bridge: stimulus pushes expected memory
// requests and read responses; a negedge monitor pops and compares them.
module tb_cache_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        drain_req, drain_done;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  cache_mem_bridge #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .WB_DEPTH      (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    bit          hit;
    int          acc_cyc;
  } resp_exp_t;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h, expected no event (cycle %0d)", name, act, cyc);
  endtask

  // Memory model: read data returns mem_lat cycles after the accepted request.
  logic [31:0] mem_rd_val = '0;
  int          mem_lat = 3;
  int          mem_resp_cyc = -10;
  bit          rd_hs = 1'b0;
  bit          spur = 1'b0;
  int          rd_cnt = 0;

  initial begin
    mem_resp_valid = 1'b0;
    mem_rdata      = 32'hDEAD_0000;
    forever begin
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_rdata      = 32'hDEAD_0000;
      if (rst) begin
        rd_cnt = 0;
      end else begin
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = mem_rd_val;
            mem_resp_cyc   = cyc;
          end
        end
        if (rd_hs) rd_cnt = mem_lat - 1;
        if (spur) begin
          mem_resp_valid = 1'b1;
          mem_rdata      = 32'h0000_0BAD;
          spur           = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on memory handshakes and responses; checks stall stability.
  initial begin
    mem_exp_t    e;
    resp_exp_t   r;
    logic        prev_stall;
    logic [64:0] prev_fields;
    prev_stall  = 1'b0;
    prev_fields = '0;
    forever begin
      @(negedge clk);
      rd_hs = !rst && mem_req_valid && mem_req_ready && !mem_we;
      if (!rst) begin
        if (prev_stall) begin
          check("stall_valid_held", mem_req_valid, 1'b1);
          check("stall_fields_stable", {mem_we, mem_addr, mem_wdata}, prev_fields);
        end
        if (mem_req_valid && mem_req_ready) begin
          if (exp_mem.size() == 0) begin
            unexpected("unexpected_mem_req", {mem_we, mem_addr, mem_wdata});
          end else begin
            e = exp_mem.pop_front();
            check("mem_we", mem_we, e.we);
            check("mem_addr", mem_addr, e.addr);
            if (e.we) check("mem_wdata", mem_wdata, e.data);
          end
        end
        if (resp_valid) begin
          if (exp_resp.size() == 0) begin
            unexpected("unexpected_resp", resp_rdata);
          end else begin
            r = exp_resp.pop_front();
            if (r.hit) check("hit_latency", cyc, r.acc_cyc);
            else       check("miss_latency", cyc, mem_resp_cyc + 1);
            check("resp_rdata", resp_rdata, r.data);
          end
        end
      end
      prev_stall  = !rst && mem_req_valid && !mem_req_ready;
      prev_fields = {mem_we, mem_addr, mem_wdata};
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request until accepted or the bound expires; acc is the cycle after acceptance.
  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output bit ok, output int acc);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    ok        = 1'b0;
    acc       = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        ok  = 1'b1;
        acc = cyc;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bit ok;
    int acc;
    do_req(1'b1, a, d, ok, acc);
    check("wr_accepted", ok, 1'b1);
    if (ok) exp_mem.push_back('{we: 1'b1, addr: a, data: d});
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input bit hit);
    bit ok;
    int acc;
    do_req(1'b0, a, 32'h0, ok, acc);
    check("rd_accepted", ok, 1'b1);
    if (ok) begin
      exp_resp.push_back('{data: d, hit: hit, acc_cyc: acc});
      if (!hit) exp_mem.push_back('{we: 1'b0, addr: a, data: 32'h0});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    drain_req     = 1'b0;
    mem_req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_drain_done", drain_done, 1'b0);
    rst = 1'b0;
    wait_cycles(1);

    // 1: reset while a write is stalled in issue with three entries buffered.
    wr(32'h100, 32'h1);
    wr(32'h104, 32'h2);
    wr(32'h108, 32'h3);
    wait_cycles(2);
    check("t1_issue_pending", mem_req_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_rst_drops_valid", mem_req_valid, 1'b0);
    exp_mem.delete();
    exp_resp.delete();
    wait_cycles(2);
    rst           = 1'b0;
    mem_req_ready = 1'b1;
    drain_req     = 1'b1;
    #1;
    check("t1_buffer_empty", drain_done, 1'b1);
    drain_req = 1'b0;
    wait_cycles(8);

    // 2: read of a freshly buffered address is forwarded.
    wr(32'h10, 32'hAA);
    rd(32'h10, 32'hAA, 1'b1);
    wait_cycles(6);

    // 3: newest duplicate wins; memory still sees both in order.
    wr(32'h10, 32'h1);
    wr(32'h10, 32'h2);
    rd(32'h10, 32'h2, 1'b1);
    wait_cycles(8);
    spur = 1'b1;
    wait_cycles(4);

    // 4: fill the buffer while memory stalls; the fifth write waits for a slot.
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'h20 + i, 32'hB0 + i);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h24;
    req_wdata = 32'hB4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_full_not_ready", req_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    mem_req_ready = 1'b1;
    wr(32'h24, 32'hB4);
    wait_cycles(20);

    // 5: read miss with memory latency and a stalled request.
    mem_req_ready = 1'b0;
    mem_rd_val    = 32'h55;
    mem_lat       = 3;
    rd(32'h40, 32'h55, 1'b0);
    wait_cycles(3);
    mem_req_ready = 1'b1;
    wait_cycles(10);

    // 6: drain with two entries; reads refused while draining.
    mem_req_ready = 1'b0;
    wr(32'h30, 32'hC0);
    wr(32'h34, 32'hC1);
    drain_req = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_rd_refused", req_ready, 1'b0);
      check("t6_not_done", drain_done, 1'b0);
      @(posedge clk);
      #1;
    end
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (drain_done) ok = 1'b1;
    end
    check("t6_drain_done", ok, 1'b1);
    check("t6_writes_issued", exp_mem.size(), 0);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h50;
    @(negedge clk);
    check("t6_idle_rd_refused", req_ready, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain_req = 1'b0;
    @(negedge clk);
    check("t6_done_low", drain_done, 1'b0);
    wait_cycles(10);

    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_resp_drained", exp_resp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
